// File: rtl/bus_pkg.sv
// Shared definitions for the SRAM bus arbiter: access sequencer states,
// master indices and the strobe counter width.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } bus_state_t;

  localparam int unsigned MASTER_CPU   = 0;
  localparam int unsigned MASTER_DBG   = 1;
  localparam int unsigned STROBE_CNT_W = 4;

  function automatic logic [1:0] master_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin chooser: a lone requester wins, and a tie goes to the
// master that was not granted last.
module rr_pick2
  import bus_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] winner
);

  always_comb begin
    winner = 2'b00;
    unique case (req)
      2'b01:   winner = master_onehot(1'(MASTER_CPU));
      2'b10:   winner = master_onehot(1'(MASTER_DBG));
      2'b11:   winner = last ? master_onehot(1'(MASTER_CPU)) : master_onehot(1'(MASTER_DBG));
      default: winner = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the asynchronous SRAM bus between the CPU and the debug/DMA loader,
// sequencing each access as setup / strobe / hold with a one-cycle ack.
module mem_bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned ADDR_WIDTH    = 16,
  parameter int unsigned DATA_WIDTH    = 16
) (
  input  logic                  clock,
  input  logic                  notReset,
  input  logic [1:0]            req,
  input  logic [1:0]            we,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic [1:0]            ack,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            grant,
  output logic [ADDR_WIDTH-1:0] memAddress,
  inout  wire  [DATA_WIDTH-1:0] memData,
  output logic                  memNotRead,
  output logic                  memNotWrite,
  output logic                  memNotCs
);

  localparam logic [STROBE_CNT_W-1:0] CNT_LOAD = STROBE_CNT_W'(STROBE_CYCLES - 1);

  bus_state_t              state;
  logic [STROBE_CNT_W-1:0] strobe_cnt;
  logic                    last;
  logic                    we_q;
  logic                    unmapped_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    drive_q;

  logic [1:0]            winner;
  logic                  win_idx;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  rr_pick2 u_pick (
    .req    (req),
    .last   (last),
    .winner (winner)
  );

  always_comb begin
    win_idx   = winner[1];
    sel_addr  = win_idx ? addr1  : addr0;
    sel_wdata = win_idx ? wdata1 : wdata0;
  end

  assign memData = drive_q ? wdata_q : 'z;

  always_ff @(posedge clock) begin
    if (!notReset) begin
      state       <= IDLE;
      strobe_cnt  <= '0;
      last        <= 1'b1;
      we_q        <= 1'b0;
      unmapped_q  <= 1'b0;
      wdata_q     <= '0;
      drive_q     <= 1'b0;
      ack         <= '0;
      grant       <= '0;
      rdata       <= '0;
      memAddress  <= '0;
      memNotRead  <= 1'b1;
      memNotWrite <= 1'b1;
      memNotCs    <= 1'b1;
    end else begin
      ack <= '0;
      unique case (state)
        IDLE: begin
          if (|winner) begin
            grant      <= winner;
            last       <= win_idx;
            we_q       <= we[win_idx];
            unmapped_q <= sel_addr[ADDR_WIDTH-1];
            wdata_q    <= sel_wdata;
            memAddress <= {1'b0, sel_addr[ADDR_WIDTH-2:0]};
            memNotCs   <= sel_addr[ADDR_WIDTH-1];
            state      <= SETUP;
          end
        end
        SETUP: begin
          strobe_cnt  <= CNT_LOAD;
          memNotRead  <= we_q;
          memNotWrite <= !we_q;
          drive_q     <= we_q;
          state       <= STROBE;
        end
        STROBE: begin
          if (strobe_cnt == '0) begin
            memNotRead  <= 1'b1;
            memNotWrite <= 1'b1;
            drive_q     <= 1'b0;
            // Upper half has no device behind it, so reads there return zero.
            if (!we_q) rdata <= unmapped_q ? '0 : memData;
            ack   <= grant;
            state <= HOLD;
          end else begin
            strobe_cnt <= strobe_cnt - 1'b1;
          end
        end
        HOLD: begin
          grant      <= '0;
          memNotCs   <= 1'b1;
          memAddress <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a small SRAM model on the shared bus.
module tb_mem_bus_arbiter;

  localparam int unsigned S = 2;

  logic        clock = 1'b0;
  logic        notReset = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [1:0]  we = 2'b00;
  logic [15:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic [1:0]  ack, grant;
  logic [15:0] rdata, memAddress;
  wire  [15:0] memData;
  logic        memNotRead, memNotWrite, memNotCs;

  logic [15:0] ram [0:255];
  int errors = 0;
  int checks = 0;
  int both_low = 0;
  int leak = 0;
  bit mon_en = 1'b0;

  mem_bus_arbiter #(
    .STROBE_CYCLES (S),
    .ADDR_WIDTH    (16),
    .DATA_WIDTH    (16)
  ) dut (
    .clock       (clock),
    .notReset    (notReset),
    .req         (req),
    .we          (we),
    .addr0       (addr0),
    .addr1       (addr1),
    .wdata0      (wdata0),
    .wdata1      (wdata1),
    .ack         (ack),
    .rdata       (rdata),
    .grant       (grant),
    .memAddress  (memAddress),
    .memData     (memData),
    .memNotRead  (memNotRead),
    .memNotWrite (memNotWrite),
    .memNotCs    (memNotCs)
  );

  always #5 clock = ~clock;

  // Released bus floats high so an undriven bus reads as FFFF.
  pullup (memData);
  assign memData = (!memNotCs && !memNotRead) ? ram[memAddress[7:0]] : 'z;
  always @(posedge clock) if (!memNotCs && !memNotWrite) ram[memAddress[7:0]] <= memData;

  always @(negedge clock) if (mon_en) begin
    if (!memNotRead && !memNotWrite) both_low++;
    if (memNotRead && memNotWrite && memData != 16'hFFFF) leak++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_access(input int m, input logic w, input logic [15:0] a, input logic [15:0] d,
                           input int drop_at, output int ack_n, output int ack_cnt,
                           output logic [15:0] rd, output int wlow, output int cs_low,
                           output logic [15:0] addr_seen, output logic [15:0] wdata_seen,
                           output logic [1:0] g1);
    ack_n = 0; ack_cnt = 0; rd = '0; wlow = 0; cs_low = 0;
    addr_seen = '0; wdata_seen = '0; g1 = '0;
    we[m] = w;
    if (m == 0) begin addr0 = a; wdata0 = d; end
    else begin addr1 = a; wdata1 = d; end
    req[m] = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clock);
      if (n == 1) g1 = grant;
      if (!memNotWrite) begin wlow++; wdata_seen = memData; end
      if (!memNotCs) cs_low++;
      if (grant != 2'b00) addr_seen = memAddress;
      if (ack[m]) begin
        ack_cnt++;
        if (ack_n == 0) begin ack_n = n; rd = rdata; end
      end
      if (n == drop_at || ack[m]) req[m] = 1'b0;
    end
  endtask

  int          an, ac, wl, cl;
  logic [15:0] rd, as, ws;
  logic [1:0]  g1;
  logic [1:0]  rr_ack [4];
  logic [15:0] rr_dat [4];
  int          rr_cyc [4];
  int          k;
  int          late_acks;

  initial begin
    ram[8'h05] = 16'h5555;
    ram[8'h20] = 16'h1234;

    // Reset held 3 cycles, then idle for 10 cycles.
    notReset = 1'b0;
    repeat (3) @(negedge clock);
    mon_en = 1'b1;
    check_eq("rst_ctrl", {ack, grant, memNotRead, memNotWrite, memNotCs}, 7'b0000111);
    check_eq("rst_rdata", rdata, 16'h0000);
    check_eq("rst_addr", memAddress, 16'h0000);
    check_eq("rst_bus", memData, 16'hFFFF);
    notReset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check_eq("idle_ctrl", {ack, grant, memNotRead, memNotWrite, memNotCs, memAddress, rdata, memData},
               {7'b0000111, 16'h0000, 16'h0000, 16'hFFFF});
    end

    // Master 0 write then read back.
    do_access(0, 1'b1, 16'h0010, 16'hBEEF, 0, an, ac, rd, wl, cl, as, ws, g1);
    check_eq("wr_grant", g1, 2'b01);
    check_eq("wr_ack_cycle", an, 4);
    check_eq("wr_ack_count", ac, 1);
    check_eq("wr_strobe_len", wl, 2);
    check_eq("wr_bus_data", ws, 16'hBEEF);
    check_eq("wr_addr", as, 16'h0010);
    check_eq("wr_ram", ram[8'h10], 16'hBEEF);
    do_access(0, 1'b0, 16'h0010, 16'h0000, 0, an, ac, rd, wl, cl, as, ws, g1);
    check_eq("rd_ack_cycle", an, 4);
    check_eq("rd_data", rd, 16'hBEEF);
    check_eq("rd_no_write", wl, 0);

    // Master 1 to unmapped space: no chip select, zero read data, no RAM change.
    do_access(1, 1'b0, 16'h8005, 16'h0000, 0, an, ac, rd, wl, cl, as, ws, g1);
    check_eq("um_grant", g1, 2'b10);
    check_eq("um_ack_cycle", an, 4);
    check_eq("um_rdata", rd, 16'h0000);
    check_eq("um_cs_low", cl, 0);
    check_eq("um_addr", as, 16'h0005);
    do_access(1, 1'b1, 16'h8005, 16'hFFFF, 0, an, ac, rd, wl, cl, as, ws, g1);
    check_eq("um_wr_ack_cycle", an, 4);
    check_eq("um_wr_cs_low", cl, 0);
    check_eq("um_wr_ram", ram[8'h05], 16'h5555);

    // Both masters saturating; last grant was master 1, so master 0 goes first.
    we = 2'b00; addr0 = 16'h0010; addr1 = 16'h0020;
    for (int i = 0; i < 4; i++) begin rr_ack[i] = '0; rr_dat[i] = '0; rr_cyc[i] = 0; end
    k = 0;
    req = 2'b11;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      if (ack != 2'b00 && k < 4) begin
        rr_ack[k] = ack; rr_dat[k] = rdata; rr_cyc[k] = n; k++;
        if (k == 4) begin req = 2'b00; break; end
      end
    end
    req = 2'b00;
    check_eq("rr_ack0", rr_ack[0], 2'b01);
    check_eq("rr_ack1", rr_ack[1], 2'b10);
    check_eq("rr_ack2", rr_ack[2], 2'b01);
    check_eq("rr_ack3", rr_ack[3], 2'b10);
    check_eq("rr_dat0", rr_dat[0], 16'hBEEF);
    check_eq("rr_dat1", rr_dat[1], 16'h1234);
    check_eq("rr_dat3", rr_dat[3], 16'h1234);
    check_eq("rr_first_cycle", rr_cyc[0], 4);
    check_eq("rr_period", rr_cyc[1] - rr_cyc[0], S + 3);
    repeat (2) @(negedge clock);

    // Reset during the second strobe cycle of a write.
    we[0] = 1'b1; addr0 = 16'h0030; wdata0 = 16'h1111; req[0] = 1'b1;
    repeat (3) @(negedge clock);
    check_eq("abort_in_strobe", {memNotRead, memNotWrite}, 2'b10);
    notReset = 1'b0; req = 2'b00;
    @(negedge clock);
    check_eq("abort_ctrl", {ack, grant, memNotRead, memNotWrite, memNotCs}, 7'b0000111);
    check_eq("abort_bus", memData, 16'hFFFF);
    check_eq("abort_addr", memAddress, 16'h0000);
    notReset = 1'b1;
    late_acks = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (ack != 2'b00) late_acks++;
    end
    check_eq("abort_no_ack", late_acks, 0);
    do_access(0, 1'b0, 16'h0010, 16'h0000, 0, an, ac, rd, wl, cl, as, ws, g1);
    check_eq("post_abort_grant", g1, 2'b01);
    check_eq("post_abort_ack", an, 4);
    check_eq("post_abort_data", rd, 16'hBEEF);

    // Master 0 drops req during SETUP; the access still completes once.
    do_access(0, 1'b0, 16'h0020, 16'h0000, 1, an, ac, rd, wl, cl, as, ws, g1);
    check_eq("drop_ack_cycle", an, 4);
    check_eq("drop_ack_count", ac, 1);
    check_eq("drop_data", rd, 16'h1234);

    check_eq("never_both_low", both_low, 0);
    check_eq("bus_released", leak, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single asynchronous SRAM bus between two masters: the CPU (master 0) and a debug/DMA loader (master 1) used by the simulation host to load and inspect RAM without halting the model. It arbitrates round-robin, sequences each access as setup / strobe / hold on the active-low SRAM strobes, and returns read data with a one-cycle acknowledge. It sits between the masters and the `sram` instance in `computer`, replacing the CPU's direct drive of `memNotRead`/`memNotWrite`.

## Interface

Parameters:
- STROBE_CYCLES, 2, cycles `memNotRead`/`memNotWrite` stay low per access (legal 1..15)
- ADDR_WIDTH, 16, master and bus address width
- DATA_WIDTH, 16, data width

Ports:
- clock  in  1  system clock, all state changes on rising edge
- notReset  in  1  reset, synchronous, active-low
- req[1:0]  in  2  per-master request; held high until that master's ack
- we[1:0]  in  2  per-master write enable (1 = write), stable while req
- addr0, addr1  in  ADDR_WIDTH  per-master address, stable while req
- wdata0, wdata1  in  DATA_WIDTH  per-master write data, stable while req
- ack[1:0]  out  2  one-cycle completion pulse for the granted master
- rdata  out  DATA_WIDTH  read data, valid only while an ack bit is high
- grant[1:0]  out  2  one-hot owner of the current access, 00 when idle
- memAddress  out  ADDR_WIDTH  SRAM address, bit 15 forced to 0
- memData  inout  DATA_WIDTH  SRAM data bus; driven only during write strobe
- memNotRead  out  1  active-low read strobe
- memNotWrite  out  1  active-low write strobe
- memNotCs  out  1  active-low chip select = granted addr[15] during SETUP/STROBE/HOLD, else 1

## Operation

- States: IDLE, SETUP, STROBE, HOLD. Reset: IDLE, all outputs inactive: ack=00, grant=00, rdata=0, memNotRead=memNotWrite=memNotCs=1, memAddress=0, memData=z, last-grant pointer = 1, so master 0 wins the first tie.
- IDLE: if any req bit is set, pick a winner, register grant, latch the winner's addr, we and wdata, and go to SETUP. With a single requester, that requester wins. With both requesting, the master not granted last wins; the pointer updates on every grant.
- SETUP, 1 cycle: address and chip select stable, strobes high, then go to STROBE.
- STROBE, STROBE_CYCLES cycles: the strobe selected by the latched we is low. On a write, memData is driven with the latched wdata for the whole STROBE. On the last STROBE cycle, rdata captures memData for a read; it captures 16'h0000 if latched addr[15]=1, because unmapped space has no device. Then go to HOLD.
- HOLD, 1 cycle: strobes high, memData released, address and chip select held, ack[winner]=1; then go to IDLE with grant=00.
- req sampled only in IDLE. Dropping req mid-access does not abort it; ack is still issued.
- Writes to addr[15]=1 complete normally with memNotCs high, so no RAM cell changes.
- memNotRead and memNotWrite are never low together. memData is never driven outside STROBE with we=1.

## Timing

- Grant edge = rising edge at which IDLE samples req. ack is high in cycle STROBE_CYCLES+2 after that edge, for exactly 1 cycle.
- Minimum back-to-back period per access: STROBE_CYCLES+3 cycles, counting the mandatory IDLE cycle.
- A master that keeps req high through its ack cycle starts a new transaction in the following IDLE, subject to round-robin. With both masters saturating, grants alternate 0,1,0,1.
- Reset low on any edge, including mid-STROBE: the next cycle is IDLE with every output at its reset value. No ack is issued and the interrupted write may be partial.
- Strobe counter width: 4 bits; it counts down from STROBE_CYCLES-1 to 0.

## Structure

- Shared package `bus_pkg`: state encoding (IDLE=2'd0, SETUP=2'd1, STROBE=2'd2, HOLD=2'd3), master index constants MASTER_CPU=0 and MASTER_DBG=1, and the strobe-counter width.
- One sub-module, `rr_pick2`: combinational round-robin chooser with inputs req[1:0] and last, and output one-hot winner. The pointer register stays in `mem_bus_arbiter`.
- Everything else (state register, strobe counter, latches, tristate) stays in `mem_bus_arbiter`.

## Test plan

- Reset held 3 cycles, then released with req=00: all outputs stay at reset values for 10 cycles, and memData is z.
- Master 0 writes 16'hBEEF to 16'h0010, then reads it back (STROBE_CYCLES=2): memNotWrite is low for exactly 2 cycles, and each ack arrives 4 cycles after its grant edge. The read returns rdata=16'hBEEF with ack[0].
- Both masters request continuously, with master 1 reading 16'h0020 (preloaded 16'h1234): grants go 0,1,0,1 starting with master 0. Every master-1 ack carries 16'h1234, and no cycle has both strobes low.
- Master 1 reads 16'h8005: memNotCs stays 1 and rdata=16'h0000 at ack. A write of 16'hFFFF to 16'h8005 leaves RAM[5] unchanged.
- notReset pulled low during the second STROBE cycle of a write: the next cycle is IDLE, strobes are high, memData is z and no ack follows. A subsequent request completes normally.
- Master 0 drops req during SETUP: the access still completes, and ack[0] pulses once.
